// File: rtl/vga_out_fmt.sv
// vga_out_fmt: display output formatter for the pattern generator stream.
// Blanks RGB outside DE, builds HSync/VSync pulses from the DE and VSync
// edges, and checks every line and frame against the expected geometry.
module vga_out_fmt #(
  parameter int PIXEL_DATA        = 8,
  parameter int COUNT_DEPTH       = 12,
  parameter int ACTIVE_HORIZONTAL = 1920,
  parameter int ACTIVE_VERTICAL   = 1080,
  parameter int H_FP              = 88,
  parameter int H_SYNC            = 44,
  parameter int V_SYNC            = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [PIXEL_DATA-1:0]  i_R_data,
  input  logic [PIXEL_DATA-1:0]  i_G_data,
  input  logic [PIXEL_DATA-1:0]  i_B_data,
  input  logic                   i_VSync,
  input  logic                   i_DE,
  input  logic                   i_err_clr,
  output logic [PIXEL_DATA-1:0]  o_R_data,
  output logic [PIXEL_DATA-1:0]  o_G_data,
  output logic [PIXEL_DATA-1:0]  o_B_data,
  output logic                   o_DE,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic                   o_frame_done,
  output logic [COUNT_DEPTH-1:0] o_line_cnt,
  output logic                   o_timing_err
);

  // Horizontal FSM states (idle, active, front porch, sync, blank)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACTIVE = 3'd1;
  localparam logic [2:0] ST_FP     = 3'd2;
  localparam logic [2:0] ST_SYNC   = 3'd3;
  localparam logic [2:0] ST_BLANK  = 3'd4;

  localparam logic [COUNT_DEPTH-1:0] CNT_MAX   = '1;
  localparam logic [COUNT_DEPTH-1:0] EXP_PIX   = COUNT_DEPTH'(ACTIVE_HORIZONTAL);
  localparam logic [COUNT_DEPTH-1:0] EXP_LINES = COUNT_DEPTH'(ACTIVE_VERTICAL);
  localparam logic [COUNT_DEPTH-1:0] FP_LAST   = (H_FP > 0) ? COUNT_DEPTH'(H_FP - 1) : '0;
  localparam logic [COUNT_DEPTH-1:0] SYNC_LAST = COUNT_DEPTH'(H_SYNC - 1);
  localparam logic [COUNT_DEPTH-1:0] VS_LAST   = COUNT_DEPTH'(V_SYNC - 1);

  logic                   de_q;
  logic                   vs_q;
  logic                   de_rise;
  logic                   de_fall;
  logic                   vs_rise;
  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [COUNT_DEPTH-1:0] porch_cnt;
  logic [COUNT_DEPTH-1:0] porch_nxt;
  logic                   early_rise;
  logic                   sync_end;
  logic [COUNT_DEPTH-1:0] pix_cnt;
  logic [COUNT_DEPTH-1:0] line_cnt;
  logic [COUNT_DEPTH-1:0] line_closed;
  logic [COUNT_DEPTH-1:0] pulse_cnt;
  logic                   first_frame;
  logic                   err_set;

  assign o_DE    = de_q;
  assign de_rise = i_DE & ~de_q;
  assign de_fall = ~i_DE & de_q;
  assign vs_rise = i_VSync & ~vs_q;

  // Video path: one register stage, colour forced to zero outside DE
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      o_R_data <= '0;
      o_G_data <= '0;
      o_B_data <= '0;
    end else begin
      de_q     <= i_DE;
      vs_q     <= i_VSync;
      o_R_data <= i_DE ? i_R_data : '0;
      o_G_data <= i_DE ? i_G_data : '0;
      o_B_data <= i_DE ? i_B_data : '0;
    end
  end

  // Horizontal FSM next state; a DE rise during porch or sync aborts the pulse
  always_comb begin
    state_nxt  = state;
    porch_nxt  = porch_cnt;
    early_rise = 1'b0;
    case (state)
      ST_IDLE, ST_BLANK: begin
        if (de_rise) state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (de_fall) begin
          porch_nxt = '0;
          state_nxt = (H_FP == 0) ? ST_SYNC : ST_FP;
        end
      end
      ST_FP: begin
        if (de_rise) begin
          state_nxt  = ST_ACTIVE;
          early_rise = 1'b1;
        end else if (porch_cnt == FP_LAST) begin
          state_nxt = ST_SYNC;
          porch_nxt = '0;
        end else begin
          porch_nxt = porch_cnt + 1'b1;
        end
      end
      ST_SYNC: begin
        if (de_rise) begin
          state_nxt  = ST_ACTIVE;
          early_rise = 1'b1;
        end else if (porch_cnt == SYNC_LAST) begin
          state_nxt = ST_BLANK;
          porch_nxt = '0;
        end else begin
          porch_nxt = porch_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign sync_end = (state == ST_SYNC) && (state_nxt == ST_BLANK);

  // Horizontal FSM registers; HSync is registered so it tracks the sync state exactly
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= ST_IDLE;
      porch_cnt <= '0;
      o_HSync   <= 1'b0;
    end else begin
      state     <= state_nxt;
      porch_cnt <= porch_nxt;
      o_HSync   <= (state_nxt == ST_SYNC);
    end
  end

  // Line count as it stands once a same-cycle DE fall has been folded in
  assign line_closed = (de_fall && line_cnt != CNT_MAX) ? line_cnt + 1'b1 : line_cnt;

  assign err_set = early_rise
                 | (de_fall && pix_cnt != EXP_PIX)
                 | (vs_rise && !first_frame && line_closed != EXP_LINES);

  // Pixel and line counters, both saturating
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (de_fall) pix_cnt <= '0;
      else if (i_DE && pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
      if (vs_rise) line_cnt <= '0;
      else line_cnt <= line_closed;
    end
  end

  // Frame status; the first frame after reset has no valid line count to report
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_frame_done <= 1'b0;
      o_line_cnt   <= '0;
      first_frame  <= 1'b1;
    end else begin
      o_frame_done <= vs_rise & ~first_frame;
      if (vs_rise && !first_frame) o_line_cnt <= line_closed;
      if (vs_rise) first_frame <= 1'b0;
    end
  end

  // VSync output: starts on a VSync rise, ends after V_SYNC complete HSync pulses
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_VSync   <= 1'b0;
      pulse_cnt <= '0;
    end else if (vs_rise) begin
      o_VSync   <= 1'b1;
      pulse_cnt <= '0;
    end else if (sync_end) begin
      if (o_VSync && pulse_cnt == VS_LAST) o_VSync <= 1'b0;
      if (pulse_cnt != CNT_MAX) pulse_cnt <= pulse_cnt + 1'b1;
    end
  end

  // Sticky timing error; a new error in the clear cycle keeps the flag set
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) o_timing_err <= 1'b0;
    else if (err_set) o_timing_err <= 1'b1;
    else if (i_err_clr) o_timing_err <= 1'b0;
  end

endmodule

// File: tb/tb_vga_out_fmt.sv
// tb_vga_out_fmt: table vectors, directed corner sequences and randomized
// frames compared cycle by cycle against an event-timing reference model.
module tb_vga_out_fmt;

  localparam int AH = 8;
  localparam int AV = 4;
  localparam int FP = 2;
  localparam int SY = 3;
  localparam int VS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  r_in, g_in, b_in;
  logic        vs_in, de_in, clr_in;
  logic [7:0]  r_out, g_out, b_out;
  logic        de_out, hs_out, vs_out, fd_out, err_out;
  logic [11:0] lc_out;

  vga_out_fmt #(
    .PIXEL_DATA(8), .COUNT_DEPTH(12), .ACTIVE_HORIZONTAL(AH), .ACTIVE_VERTICAL(AV),
    .H_FP(FP), .H_SYNC(SY), .V_SYNC(VS)
  ) dut (
    .i_clk(clk), .i_rst(rst_n),
    .i_R_data(r_in), .i_G_data(g_in), .i_B_data(b_in),
    .i_VSync(vs_in), .i_DE(de_in), .i_err_clr(clr_in),
    .o_R_data(r_out), .o_G_data(g_out), .o_B_data(b_out),
    .o_DE(de_out), .o_HSync(hs_out), .o_VSync(vs_out),
    .o_frame_done(fd_out), .o_line_cnt(lc_out), .o_timing_err(err_out)
  );

  // Free-running pixel clock
  always #5 clk = ~clk;

  typedef struct {
    logic       de;
    logic [7:0] r, g, b;
    logic       exp_de;
    logic [7:0] exp_r, exp_g, exp_b;
  } vec_t;

  vec_t vecs[8];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: times of DE edges, plain line/frame tallies
  int          cyc;
  logic        m_de_q, m_vs_q;
  int          last_fall;
  bit          killed;
  int          pix, lines;
  bit          first;
  bit          vs_on;
  int          pulses;
  logic        e_de, e_hs, e_vs, e_fd, e_err;
  logic [7:0]  e_r, e_g, e_b;
  logic [11:0] e_lc;

  int fd_seen;
  int lc_at_fd;
  int vs_high_cnt;
  bit rnd_clr;
  int fd_before;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    m_de_q = 0; m_vs_q = 0; last_fall = -1; killed = 0;
    pix = 0; lines = 0; first = 1; vs_on = 0; pulses = 0;
    e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0; e_err = 0;
    e_r = 0; e_g = 0; e_b = 0; e_lc = 0;
  endtask

  // Expected outputs after the coming clock edge, from the current inputs
  task automatic model_edge();
    bit rise, fall, vrise, err_set, pend;
    int end_c;
    rise    = de_in && !m_de_q;
    fall    = !de_in && m_de_q;
    vrise   = vs_in && !m_vs_q;
    err_set = 0;
    if (fall) begin
      last_fall = cyc;
      killed    = 0;
    end else if (rise) begin
      if (last_fall >= 0 && !killed && cyc <= last_fall + FP + SY) err_set = 1;
      killed = 1;
    end
    end_c = last_fall + FP + SY;
    e_hs  = (last_fall >= 0) && !killed && (cyc + 1 >= last_fall + 1 + FP) && (cyc + 1 <= end_c);
    pend  = (last_fall >= 0) && !killed && (cyc == end_c);
    if (fall) begin
      if (pix != AH) err_set = 1;
      pix = 0;
      if (lines < 4095) lines++;
    end else if (de_in) begin
      if (pix < 4095) pix++;
    end
    e_fd = 0;
    if (vrise) begin
      if (!first) begin
        e_fd = 1;
        e_lc = 12'(lines);
        if (lines != AV) err_set = 1;
      end
      lines = 0;
      first = 0;
      vs_on = 1;
      pulses = 0;
    end else if (pend && vs_on) begin
      pulses++;
      if (pulses == VS) vs_on = 0;
    end
    e_vs = vs_on;
    if (err_set) e_err = 1;
    else if (clr_in) e_err = 0;
    e_de = de_in;
    e_r = de_in ? r_in : 8'h00;
    e_g = de_in ? g_in : 8'h00;
    e_b = de_in ? b_in : 8'h00;
    m_de_q = de_in;
    m_vs_q = vs_in;
  endtask

  task automatic apply_stimulus(input logic de_v, input logic vs_v, input logic [7:0] rv,
                                input logic [7:0] gv, input logic [7:0] bv, input logic clr_v);
    de_in = de_v; vs_in = vs_v; r_in = rv; g_in = gv; b_in = bv; clr_in = clr_v;
    model_edge();
    @(posedge clk);
    #1;
    check_output("o_DE", de_out, e_de);
    check_output("o_R", r_out, e_r);
    check_output("o_G", g_out, e_g);
    check_output("o_B", b_out, e_b);
    check_output("o_HSync", hs_out, e_hs);
    check_output("o_VSync", vs_out, e_vs);
    check_output("o_frame_done", fd_out, e_fd);
    check_output("o_line_cnt", lc_out, e_lc);
    check_output("o_timing_err", err_out, e_err);
    if (fd_out) begin
      fd_seen++;
      lc_at_fd = int'(lc_out);
    end
    if (vs_out) vs_high_cnt++;
    cyc++;
  endtask

  function automatic logic pick_clr();
    return rnd_clr && ($urandom % 8 == 0);
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, " o_R"}, r_out, 0);
    check_output({tag, " o_G"}, g_out, 0);
    check_output({tag, " o_B"}, b_out, 0);
    check_output({tag, " o_DE"}, de_out, 0);
    check_output({tag, " o_HSync"}, hs_out, 0);
    check_output({tag, " o_VSync"}, vs_out, 0);
    check_output({tag, " o_frame_done"}, fd_out, 0);
    check_output({tag, " o_line_cnt"}, lc_out, 0);
    check_output({tag, " o_timing_err"}, err_out, 0);
  endtask

  task automatic pix_step(input logic de_v, input bit rnd, input logic clr_v);
    if (rnd) apply_stimulus(de_v, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom), clr_v);
    else     apply_stimulus(de_v, 1'b0, 8'h20, 8'h20, 8'h20, clr_v);
  endtask

  task automatic line(input int npix, input int nblank, input bit rnd);
    for (int i = 0; i < npix; i++) pix_step(1'b1, rnd, pick_clr());
    for (int i = 0; i < nblank; i++) pix_step(1'b0, rnd, pick_clr());
  endtask

  task automatic vs_start();
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 8'h20, 8'h20, 8'h20, pick_clr());
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b0, 8'h20, 8'h20, 8'h20, pick_clr());
  endtask

  task automatic frame(input int nlines, input bit rnd);
    int np;
    vs_start();
    for (int l = 0; l < nlines; l++) begin
      np = (rnd && ($urandom % 6 == 0)) ? int'($urandom_range(6, 9)) : AH;
      line(np, rnd ? int'($urandom_range(1, 14)) : 10, rnd);
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0; de_in = 0; vs_in = 0; clr_in = 0;
    #1;
    check_all_zero("async reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    cyc = 0; fd_seen = 0; lc_at_fd = 0; vs_high_cnt = 0; rnd_clr = 0;
    rst_n = 1'b0; de_in = 0; vs_in = 0; clr_in = 0; r_in = 0; g_in = 0; b_in = 0;
    model_reset();

    vecs[0] = '{1'b1, 8'h11, 8'h22, 8'h33, 1'b1, 8'h11, 8'h22, 8'h33};
    vecs[1] = '{1'b1, 8'h44, 8'h55, 8'h66, 1'b1, 8'h44, 8'h55, 8'h66};
    vecs[2] = '{1'b0, 8'h77, 8'h88, 8'h99, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 8'h01, 8'h02, 8'h03, 1'b1, 8'h01, 8'h02, 8'h03};
    vecs[5] = '{1'b0, 8'hAA, 8'hBB, 8'hCC, 1'b0, 8'h00, 8'h00, 8'h00};
    vecs[6] = '{1'b1, 8'hFF, 8'h00, 8'h80, 1'b1, 8'hFF, 8'h00, 8'h80};
    vecs[7] = '{1'b0, 8'h5A, 8'hA5, 8'h3C, 1'b0, 8'h00, 8'h00, 8'h00};

    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Video path vectors
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(vecs[i].de, 1'b0, vecs[i].r, vecs[i].g, vecs[i].b, 1'b0);
      check_output("vec o_DE", de_out, vecs[i].exp_de);
      check_output("vec o_R", r_out, vecs[i].exp_r);
      check_output("vec o_G", g_out, vecs[i].exp_g);
      check_output("vec o_B", b_out, vecs[i].exp_b);
    end
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, 8'h20, 8'h20, 8'h20, i == 11);

    // Nominal frames
    frame(AV, 0);
    vs_high_cnt = 0;
    frame(AV, 0);
    check_output("vsync width", vs_high_cnt, 36);
    frame(AV, 0);
    check_output("nominal fd count", fd_seen, 2);
    check_output("nominal line cnt", lc_at_fd, AV);
    check_output("nominal err", err_out, 0);

    // Short line
    vs_start();
    check_output("fd count 3", fd_seen, 3);
    check_output("err before short", err_out, 0);
    for (int i = 0; i < 7; i++) pix_step(1'b1, 0, 1'b0);
    pix_step(1'b0, 0, 1'b0);
    check_output("short line err", err_out, 1);
    for (int i = 0; i < 8; i++) pix_step(1'b0, 0, 1'b0);
    check_output("short line sticky", err_out, 1);
    pix_step(1'b0, 0, 1'b1);
    check_output("err clr", err_out, 0);
    for (int l = 0; l < 3; l++) line(AH, 10, 0);

    // Early DE inside HSync, then a 5-line frame
    vs_start();
    check_output("fd count 4", fd_seen, 4);
    check_output("err after 4-line", err_out, 0);
    line(AH, 3, 0);
    check_output("hsync before early", hs_out, 1);
    pix_step(1'b1, 0, 1'b0);
    check_output("early hsync drop", hs_out, 0);
    check_output("early err", err_out, 1);
    for (int i = 0; i < 7; i++) pix_step(1'b1, 0, 1'b0);
    for (int i = 0; i < 10; i++) pix_step(1'b0, 0, i == 7);
    check_output("err cleared", err_out, 0);
    for (int l = 0; l < 3; l++) line(AH, 10, 0);
    vs_start();
    check_output("fd count 5", fd_seen, 5);
    check_output("wrong frame line cnt", lc_at_fd, 5);
    check_output("wrong frame err", err_out, 1);

    // Reset in the middle of HSync
    line(AH, 3, 0);
    check_output("hsync before reset", hs_out, 1);
    async_reset();
    fd_before = fd_seen;
    frame(AV, 0);
    check_output("no fd after reset", fd_seen, fd_before);
    vs_start();
    check_output("fd after reset", fd_seen, fd_before + 1);
    check_output("line cnt after reset", lc_at_fd, AV);

    // Randomized frames
    rnd_clr = 1;
    for (int f = 0; f < 4; f++) frame(int'($urandom_range(3, 5)), 1);
    rnd_clr = 0;
    vs_start();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
